// File: rtl/uart_pkg.sv
// Shared UART constants and the divisor helper for the baud generator, uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DEF  = 100000000;
  localparam int unsigned BAUD_RATE_DEF = 115200;

  // Rounded clk/(baud*os) in fixed point: result[frac_w-1:0] is the fraction, the rest the integer.
  function automatic logic [63:0] baud_div(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned os,
                                           input int unsigned     frac_w);
    longint unsigned den;
    den = baud * os;
    if (den == 0) den = 1;
    return 64'(((clk_hz << frac_w) + (den >> 1)) / den);
  endfunction

endpackage

// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator: oversample tick, baud tick and oversample phase index,
// with a shadowed runtime divisor that switches only on period boundaries.
module baud_gen_frac
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
  parameter int unsigned BAUD_RATE  = BAUD_RATE_DEF,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    cfg_load,
  input  logic [DIV_W-1:0]        div_int,
  input  logic [FRAC_W-1:0]       div_frac,
  output logic                    tick_os,
  output logic                    tick_baud,
  output logic [((OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1)-1:0] os_phase
);

  localparam int unsigned PH_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned CNT_W = DIV_W + 1;
  localparam int unsigned SUM_W = FRAC_W + 1;

  localparam logic [63:0]       DEF_DIV  = baud_div(64'(CLK_FREQ), 64'(BAUD_RATE),
                                                    64'(OVERSAMPLE), FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_DIV >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_DIV);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic              tick_os_q, tick_os_d;
  logic              tick_baud_q, tick_baud_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d, act_int_q, act_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d, act_frac_q, act_frac_d;

  logic [CNT_W-1:0]  div_eff;
  logic [CNT_W-1:0]  period_end;
  logic              wrap;
  logic [DIV_W-1:0]  nxt_int;
  logic [FRAC_W-1:0] nxt_frac;

  // A load arriving on the boundary cycle bypasses the shadow so it governs the new period.
  always_comb begin
    div_eff    = (act_int_q == '0) ? CNT_W'(1) : CNT_W'(act_int_q);
    period_end = CNT_W'(div_eff + CNT_W'(extra_q) - CNT_W'(1));
    wrap       = en && (cnt_q == period_end);
    nxt_int    = cfg_load ? div_int  : sh_int_q;
    nxt_frac   = cfg_load ? div_frac : sh_frac_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    extra_d     = extra_q;
    phase_d     = phase_q;
    tick_os_d   = 1'b0;
    tick_baud_d = 1'b0;
    sh_int_d    = sh_int_q;
    sh_frac_d   = sh_frac_q;
    act_int_d   = act_int_q;
    act_frac_d  = act_frac_q;

    if (cfg_load) begin
      sh_int_d  = div_int;
      sh_frac_d = div_frac;
    end

    if (!en) begin
      cnt_d      = '0;
      acc_d      = '0;
      extra_d    = 1'b0;
      phase_d    = '0;
      act_int_d  = nxt_int;
      act_frac_d = nxt_frac;
    end else begin
      // os_phase advances once the tick it labels has been presented
      if (tick_os_q) begin
        phase_d = (phase_q == PH_W'(OVERSAMPLE - 1)) ? '0 : PH_W'(phase_q + PH_W'(1));
      end
      if (wrap) begin
        cnt_d              = '0;
        {extra_d, acc_d}   = SUM_W'(SUM_W'(acc_q) + SUM_W'(nxt_frac));
        act_int_d          = nxt_int;
        act_frac_d         = nxt_frac;
        tick_os_d          = 1'b1;
        tick_baud_d        = (phase_d == PH_W'(OVERSAMPLE - 1));
      end else begin
        cnt_d = CNT_W'(cnt_q + CNT_W'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      extra_q     <= 1'b0;
      phase_q     <= '0;
      tick_os_q   <= 1'b0;
      tick_baud_q <= 1'b0;
      sh_int_q    <= DEF_INT;
      sh_frac_q   <= DEF_FRAC;
      act_int_q   <= DEF_INT;
      act_frac_q  <= DEF_FRAC;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      extra_q     <= extra_d;
      phase_q     <= phase_d;
      tick_os_q   <= tick_os_d;
      tick_baud_q <= tick_baud_d;
      sh_int_q    <= sh_int_d;
      sh_frac_q   <= sh_frac_d;
      act_int_q   <= act_int_d;
      act_frac_q  <= act_frac_d;
    end
  end

  assign tick_os   = tick_os_q;
  assign tick_baud = tick_baud_q;
  assign os_phase  = phase_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: expected tick times/phases queued per run, popped on tick_os.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        tick_os;
  logic        tick_baud;
  logic [3:0]  os_phase;

  baud_gen_frac dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_load  (cfg_load),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .tick_os   (tick_os),
    .tick_baud (tick_baud),
    .os_phase  (os_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned rel;
    logic [3:0]  phase;
    logic        baud;
  } exp_t;

  typedef struct {
    logic [15:0] di;
    logic [3:0]  df;
    int unsigned first;
    int unsigned span;
  } vec_t;

  exp_t        sb[$];
  int unsigned tick_t[$];
  vec_t        vt[6];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned start = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tick k (1-based) after enable: k*div + floor((k-1)*frac/16) enabled edges
  function automatic int unsigned exp_rel(input int unsigned k, input int unsigned di,
                                          input int unsigned df);
    int unsigned d;
    d = (di == 0) ? 1 : di;
    return k * d + ((k - 1) * df) / 16;
  endfunction

  task automatic push(input int unsigned k, input int unsigned rel);
    exp_t e;
    e.rel   = rel;
    e.phase = 4'((k - 1) % 16);
    e.baud  = (((k - 1) % 16) == 15);
    sb.push_back(e);
  endtask

  task automatic step_mon();
    exp_t e;
    @(negedge clk);
    if (tick_os) begin
      tick_t.push_back(cyc - start);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_tick: tick_os at rel %0d, expected none", cyc - start);
      end else begin
        e = sb.pop_front();
        check("tick_time", 64'(cyc - start), 64'(e.rel));
        check("os_phase", 64'(os_phase), 64'(e.phase));
        check("tick_baud", 64'(tick_baud), 64'(e.baud));
      end
    end else if (tick_baud) begin
      n_cmp++;
      n_bad++;
      $display("FAIL lone_baud: tick_baud=1 without tick_os at rel %0d, expected 0", cyc - start);
    end
  endtask

  task automatic mon_cycles(input int n);
    for (int i = 0; i < n; i++) step_mon();
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      step_mon();
      k++;
    end
    check("drain_outstanding", 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; cfg_load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] di, input logic [3:0] df);
    @(posedge clk); #1;
    div_int = di; div_frac = df; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic start_en();
    @(posedge clk); #1;
    en = 1'b1;
    start = cyc;
    tick_t.delete();
  endtask

  initial begin
    vt[0] = '{16'd54, 4'd4,  54, 868};
    vt[1] = '{16'd10, 4'd0,  10, 160};
    vt[2] = '{16'd3,  4'd8,  3,  56};
    vt[3] = '{16'd0,  4'd0,  1,  16};
    vt[4] = '{16'd1,  4'd15, 1,  31};
    vt[5] = '{16'd7,  4'd1,  7,  113};

    rst = 1'b1; en = 1'b0; cfg_load = 1'b0; div_int = '0; div_frac = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick_os", 64'(tick_os), 64'd0);
    check("rst_tick_baud", 64'(tick_baud), 64'd0);
    check("rst_os_phase", 64'(os_phase), 64'd0);
    rst = 1'b0;

    // Table runs: spacing pattern, phase/baud labelling, first-tick latency, baud period
    for (int v = 0; v < 6; v++) begin
      do_reset();
      load_cfg(vt[v].di, vt[v].df);
      start_en();
      for (int k = 1; k <= 34; k++) push(k, exp_rel(k, vt[v].di, vt[v].df));
      drain(34 * (vt[v].first + 2) + 40);
      if (tick_t.size() >= 32) begin
        check("first_tick", 64'(tick_t[0]), 64'(vt[v].first));
        check("baud_period", 64'(tick_t[31] - tick_t[15]), 64'(vt[v].span));
      end else begin
        check("tick_count", 64'(tick_t.size()), 64'd32);
      end
      en = 1'b0;
    end

    // Reset defaults with no load, then mid-period load of 10/0
    do_reset();
    start_en();
    push(1, 54);
    push(2, 108);
    for (int k = 3; k <= 12; k++) push(k, 108 + 10 * (k - 2));
    mon_cycles(75);
    cfg_load = 1'b1; div_int = 16'd10; div_frac = 4'd0;
    step_mon();
    cfg_load = 1'b0;
    drain(300);
    en = 1'b0;

    // en low for 5 cycles mid-bit, then restart from phase 0
    do_reset();
    load_cfg(16'd10, 4'd0);
    start_en();
    for (int k = 1; k <= 3; k++) push(k, 10 * k);
    mon_cycles(34);
    drain(5);
    en = 1'b0;
    mon_cycles(5);
    check("phase_while_off", 64'(os_phase), 64'd0);
    start_en();
    for (int k = 1; k <= 17; k++) push(k, 10 * k);
    drain(250);
    en = 1'b0;

    // Async reset while tick_os is high, then defaults restored
    do_reset();
    load_cfg(16'd10, 4'd0);
    start_en();
    push(1, 10);
    push(2, 20);
    drain(60);
    #1;
    rst = 1'b1;
    #1;
    check("async_tick_os", 64'(tick_os), 64'd0);
    check("async_tick_baud", 64'(tick_baud), 64'd0);
    check("async_os_phase", 64'(os_phase), 64'd0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    start_en();
    for (int k = 1; k <= 5; k++) push(k, exp_rel(k, 54, 4));
    drain(400);
    check("post_rst_5th_tick", 64'(tick_t.size() >= 5 ? tick_t[4] : 0), 64'd271);
    en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
